// File: rtl/script_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : script_mem_pkg
// Purpose  : Shared types and helpers for the banked script memory.
// Revision : 1.0 - initial release
// ============================================================================
package script_mem_pkg;

    localparam int C_READER_ADDR_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RD        = 2'd1,
        ST_ACK       = 2'd2,
        ST_SWAP_WAIT = 2'd3
    } state_t;

    // Width of a host row index; kept at least 1 so a one-row bank still has an address bit.
    function automatic int f_host_idx_w(input int axi_w, input int size);
        int rows;
        rows = size / (axi_w / 32);
        return (rows > 1) ? $clog2(rows) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/script_bank_ram.sv
`default_nettype none
// ============================================================================
// Module   : script_bank_ram
// Purpose  : One script bank: a host-width write port, N replicated 32-bit
//            synchronous read copies and, with SCRIPT_MEM_BANKED_READBACK_EN,
//            one extra host-width read copy.
// Revision : 1.0 - initial release
// ============================================================================
module script_bank_ram
    import script_mem_pkg::*;
#(
    parameter int C_DATA_W = 32,
    parameter int C_SIZE   = 2048,
    parameter int C_NUM_RD = 1
) (
    input  logic                                   clk,
    input  logic                                   i_we,
    input  logic [f_host_idx_w(C_DATA_W,C_SIZE)-1:0] i_waddr,
    input  logic [C_DATA_W-1:0]                    i_wdata,
`ifdef SCRIPT_MEM_BANKED_READBACK_EN
    input  logic [f_host_idx_w(C_DATA_W,C_SIZE)-1:0] i_host_raddr,
    output logic [C_DATA_W-1:0]                    o_host_rdata,
`endif
    input  logic [C_NUM_RD*$clog2(C_SIZE)-1:0]     i_raddr,
    output logic [C_NUM_RD*32-1:0]                 o_rdata
);

    localparam int C_LANES  = C_DATA_W / 32;
    localparam int C_LB     = $clog2(C_LANES);
    localparam int C_ROWS   = C_SIZE / C_LANES;
    localparam int C_ROW_W  = f_host_idx_w(C_DATA_W, C_SIZE);
    localparam int C_WORD_W = $clog2(C_SIZE);

    genvar gi;
    generate
        for (gi = 0; gi < C_NUM_RD; gi++) begin : g_rd
            logic [C_DATA_W-1:0] r_mem [C_ROWS];
            logic [31:0]         r_q;
            logic [C_ROW_W-1:0]  w_row;
            logic [31:0]         w_lane;

            assign w_row  = C_ROW_W'(i_raddr[gi*C_WORD_W +: C_WORD_W] >> C_LB);
            assign w_lane = 32'(i_raddr[gi*C_WORD_W +: C_WORD_W]) % C_LANES;

            always_ff @(posedge clk) begin
                if (i_we) begin
                    r_mem[i_waddr] <= i_wdata;
                end
                r_q <= r_mem[w_row][32*w_lane +: 32];
            end

            assign o_rdata[32*gi +: 32] = r_q;
        end
    endgenerate

`ifdef SCRIPT_MEM_BANKED_READBACK_EN
    logic [C_DATA_W-1:0] r_host_mem [C_ROWS];
    logic [C_DATA_W-1:0] r_host_q;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_host_mem[i_waddr] <= i_wdata;
        end
        r_host_q <= r_host_mem[i_host_raddr];
    end

    assign o_host_rdata = r_host_q;
`endif

endmodule
`default_nettype wire

// File: rtl/script_mem_banked.sv
`default_nettype none
// ============================================================================
// Module   : script_mem_banked
// Purpose  : Double-buffered multi-reader script memory with host req/ack
//            access to the shadow bank and idle-synchronised bank swap.
//            Host read-back is built only with SCRIPT_MEM_BANKED_READBACK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module script_mem_banked
    import script_mem_pkg::*;
#(
    parameter int C_AXI_WIDTH       = 32,
    parameter int C_MAX_SCRIPT_SIZE = 2048,
    parameter int C_NUM_CHANNELS    = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [$clog2(4*C_MAX_SCRIPT_SIZE)-1:0] a,
    input  logic [C_AXI_WIDTH-1:0]                d,
    input  logic                                  we,
    input  logic                                  req,
    output logic                                  ack,
    output logic [C_AXI_WIDTH-1:0]                qspo,
    input  logic                                  swap_req,
    output logic                                  swap_done,
    output logic                                  active_bank,
    input  logic [C_NUM_CHANNELS-1:0]             ch_idle,
    input  logic [16*C_NUM_CHANNELS-1:0]          dpra,
    output logic [32*C_NUM_CHANNELS-1:0]          qdpo
);

    localparam int C_HB     = $clog2(C_AXI_WIDTH / 8);
    localparam int C_ROW_W  = f_host_idx_w(C_AXI_WIDTH, C_MAX_SCRIPT_SIZE);
    localparam int C_WORD_W = $clog2(C_MAX_SCRIPT_SIZE);

    state_t                   r_state;
    logic                     r_ack;
    logic [C_AXI_WIDTH-1:0]   r_qspo;
    logic                     r_swap_done;
    logic                     r_active;
    logic                     r_armed;

    logic [C_ROW_W-1:0]                     w_host_row;
    logic                                   w_wr;
    logic [C_NUM_CHANNELS*C_WORD_W-1:0]     w_raddr;
    logic [32*C_NUM_CHANNELS-1:0]           w_q0;
    logic [32*C_NUM_CHANNELS-1:0]           w_q1;
    logic                                   w_unused;

    assign w_host_row = C_ROW_W'(a >> C_HB);
    assign w_unused   = ^a[C_HB-1:0];
    assign w_wr       = (r_state == ST_IDLE) && req && !r_ack && we;

`ifdef SCRIPT_MEM_BANKED_READBACK_EN
    logic [C_AXI_WIDTH-1:0] w_host_q0;
    logic [C_AXI_WIDTH-1:0] w_host_q1;
`endif

    script_bank_ram #(
        .C_DATA_W (C_AXI_WIDTH),
        .C_SIZE   (C_MAX_SCRIPT_SIZE),
        .C_NUM_RD (C_NUM_CHANNELS)
    ) u_bank0 (
        .clk          (clk),
        .i_we         (w_wr && r_active),
        .i_waddr      (w_host_row),
        .i_wdata      (d),
`ifdef SCRIPT_MEM_BANKED_READBACK_EN
        .i_host_raddr (w_host_row),
        .o_host_rdata (w_host_q0),
`endif
        .i_raddr      (w_raddr),
        .o_rdata      (w_q0)
    );

    script_bank_ram #(
        .C_DATA_W (C_AXI_WIDTH),
        .C_SIZE   (C_MAX_SCRIPT_SIZE),
        .C_NUM_RD (C_NUM_CHANNELS)
    ) u_bank1 (
        .clk          (clk),
        .i_we         (w_wr && !r_active),
        .i_waddr      (w_host_row),
        .i_wdata      (d),
`ifdef SCRIPT_MEM_BANKED_READBACK_EN
        .i_host_raddr (w_host_row),
        .o_host_rdata (w_host_q1),
`endif
        .i_raddr      (w_raddr),
        .o_rdata      (w_q1)
    );

    // Host access wins over a swap request seen in the same IDLE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ack       <= 1'b0;
            r_qspo      <= '0;
            r_swap_done <= 1'b0;
            r_active    <= 1'b0;
            r_armed     <= 1'b1;
        end else begin
            r_swap_done <= 1'b0;
            if (!swap_req) begin
                r_armed <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (req && !r_ack) begin
                        if (we) begin
                            r_ack   <= 1'b1;
                            r_state <= ST_ACK;
                        end else begin
`ifdef SCRIPT_MEM_BANKED_READBACK_EN
                            r_state <= ST_RD;
`else
                            r_ack   <= 1'b1;
                            r_qspo  <= '0;
                            r_state <= ST_ACK;
`endif
                        end
                    end else if (swap_req && r_armed) begin
                        r_state <= ST_SWAP_WAIT;
                    end
                end
`ifdef SCRIPT_MEM_BANKED_READBACK_EN
                ST_RD: begin
                    r_qspo  <= r_active ? w_host_q0 : w_host_q1;
                    r_ack   <= 1'b1;
                    r_state <= ST_ACK;
                end
`endif
                ST_ACK: begin
                    if (!req) begin
                        r_ack   <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_SWAP_WAIT: begin
                    if (!swap_req) begin
                        r_state <= ST_IDLE;
                    end else if (&ch_idle) begin
                        r_active    <= ~r_active;
                        r_swap_done <= 1'b1;
                        r_armed     <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Bank select and range flag are captured alongside the address so the
    // returned word belongs to the bank that was active when it was asked for.
    genvar gc;
    generate
        for (gc = 0; gc < C_NUM_CHANNELS; gc++) begin : g_reader
            logic r_oor;
            logic r_rsel;

            assign w_raddr[C_WORD_W*gc +: C_WORD_W] = dpra[C_READER_ADDR_W*gc +: C_WORD_W];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_oor  <= 1'b1;
                    r_rsel <= 1'b0;
                end else begin
                    r_oor  <= 32'(dpra[C_READER_ADDR_W*gc +: C_READER_ADDR_W]) >= 32'(C_MAX_SCRIPT_SIZE);
                    r_rsel <= r_active;
                end
            end

            assign qdpo[32*gc +: 32] = r_oor  ? 32'd0 :
                                       r_rsel ? w_q1[32*gc +: 32] : w_q0[32*gc +: 32];
        end
    endgenerate

    assign ack         = r_ack;
    assign qspo        = r_qspo;
    assign swap_done   = r_swap_done;
    assign active_bank = r_active;

endmodule
`default_nettype wire
